mem_port_arbiter: RTL and testbench

Two-requester arbiter for the single-ported unified instruction/data memory in the multicycle MIPS core. It shares the memory between the CPU's memory port and a host port, such as a program loader or debug DMA. The CPU has default priority, and a starvation counter guarantees the host a bounded burst. The arbiter sits between the CPU datapath (the IorD-muxed address, the B register write data, and the MemRead/MemWrite controls) and the memory, and returns a stall that freezes the CPU's multicycle controller.

---
 rtl/mem_port_arbiter_pkg.sv | 15 +
 rtl/mem_port_arbiter_sat_counter.sv | 33 +++
 rtl/mem_port_arbiter.sv | 141 ++++++++++++++
 tb/tb_mem_port_arbiter.sv | 298 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_port_arbiter_pkg.sv
// mem_arb_pkg: shared encodings for the memory port arbiter.
//   OWN_*       : values driven on the arbiter's owner output
//   arb_state_t : arbitration FSM states
package mem_arb_pkg;

    localparam logic [1:0] OWN_NONE = 2'b00;
    localparam logic [1:0] OWN_CPU  = 2'b01;
    localparam logic [1:0] OWN_HOST = 2'b10;

    typedef enum logic {
        CPU_PRI    = 1'b0,
        HOST_BURST = 1'b1
    } arb_state_t;

endpackage

// File: rtl/mem_port_arbiter_sat_counter.sv
// sat_counter: saturating up-counter with synchronous clear.
//   clk, reset : clock, asynchronous active-high reset
//   inc        : count up by one (held once the limit is reached)
//   clr        : return to zero; wins over inc
//   at_limit   : count equals LIMIT
module sat_counter #(
    parameter int W     = 4,
    parameter int LIMIT = 7
) (
    input  logic clk,
    input  logic reset,
    input  logic inc,
    input  logic clr,
    output logic at_limit
);

    localparam logic [W-1:0] LIMIT_V = W'(LIMIT);

    logic [W-1:0] count;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (inc && (count != LIMIT_V)) begin
            count <= count + 1'b1;
        end
    end

    assign at_limit = (count == LIMIT_V);

endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares a single-ported memory between the CPU memory
// port and a host port. The CPU has default priority; a host refused for
// MAX_WAIT consecutive cycles is promoted for up to MAX_HOST_BURST beats.
//   clk, reset                      : clock, asynchronous active-high reset
//   cpu_req/we/addr/wdata, cpu_rdata: CPU access port
//   cpu_stall                       : CPU request refused this cycle
//   host_req/we/addr/wdata          : host access port
//   host_ack, host_rdata            : host beat completed / its read data
//   mem_addr/wdata/read/write/rdata : memory side (combinational read)
//   owner                           : current grant (none / CPU / host)
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W         = 32,
    parameter int DATA_W         = 32,
    parameter int MAX_WAIT       = 8,
    parameter int MAX_HOST_BURST = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic              cpu_stall,
    input  logic              host_req,
    input  logic              host_we,
    input  logic [ADDR_W-1:0] host_addr,
    input  logic [DATA_W-1:0] host_wdata,
    output logic              host_ack,
    output logic [DATA_W-1:0] host_rdata,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_read,
    output logic              mem_write,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic [1:0]        owner
);

    localparam int WAIT_W  = $clog2(MAX_WAIT + 1);
    localparam int BURST_W = $clog2(MAX_HOST_BURST + 1);

    arb_state_t state;

    logic cpu_grant;
    logic host_grant;
    logic wait_inc, wait_clr, wait_at_limit;
    logic burst_inc, burst_clr, burst_at_limit;
    logic promote;
    logic leave_burst;

    // Grants are forced low during reset so a pending write cannot land.
    always_comb begin
        cpu_grant  = 1'b0;
        host_grant = 1'b0;
        if (!reset) begin
            if (state == CPU_PRI) begin
                cpu_grant  = cpu_req;
                host_grant = host_req && !cpu_req;
            end else begin
                host_grant = host_req;
                cpu_grant  = cpu_req && !host_req;
            end
        end
    end

    // The counters hold their terminal value, so the compare sits one below
    // the nominal count: the MAX_WAIT-th refusal is the one that promotes.
    assign promote     = (state == CPU_PRI) && cpu_grant && host_req && wait_at_limit;
    assign leave_burst = (state == HOST_BURST) &&
                         (!host_req || (host_grant && cpu_req && burst_at_limit));

    assign wait_inc  = (state == CPU_PRI) && cpu_grant && host_req && !wait_at_limit;
    assign wait_clr  = !wait_inc;

    // Host beats only count against the burst while the CPU is being held off.
    assign burst_inc = (state == HOST_BURST) && host_grant && cpu_req;
    assign burst_clr = (state == CPU_PRI) || leave_burst;

    sat_counter #(
        .W     (WAIT_W),
        .LIMIT (MAX_WAIT - 1)
    ) u_wait_cnt (
        .clk      (clk),
        .reset    (reset),
        .inc      (wait_inc),
        .clr      (wait_clr),
        .at_limit (wait_at_limit)
    );

    sat_counter #(
        .W     (BURST_W),
        .LIMIT (MAX_HOST_BURST - 1)
    ) u_burst_cnt (
        .clk      (clk),
        .reset    (reset),
        .inc      (burst_inc),
        .clr      (burst_clr),
        .at_limit (burst_at_limit)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= CPU_PRI;
        end else begin
            case (state)
                CPU_PRI:    if (promote)     state <= HOST_BURST;
                HOST_BURST: if (leave_burst) state <= CPU_PRI;
                default:                     state <= CPU_PRI;
            endcase
        end
    end

    always_comb begin
        mem_addr  = '0;
        mem_wdata = '0;
        mem_read  = 1'b0;
        mem_write = 1'b0;
        owner     = OWN_NONE;
        if (cpu_grant) begin
            mem_addr  = cpu_addr;
            mem_wdata = cpu_wdata;
            mem_read  = !cpu_we;
            mem_write = cpu_we;
            owner     = OWN_CPU;
        end else if (host_grant) begin
            mem_addr  = host_addr;
            mem_wdata = host_wdata;
            mem_read  = !host_we;
            mem_write = host_we;
            owner     = OWN_HOST;
        end
    end

    assign cpu_rdata  = mem_rdata;
    assign host_rdata = mem_rdata;
    assign cpu_stall  = cpu_req && !cpu_grant && !reset;
    assign host_ack   = host_grant;

endmodule

// File: tb/tb_mem_port_arbiter.sv
module tb_mem_port_arbiter;

    logic        clk;
    logic        reset;
    logic        cpu_req, cpu_we;
    logic [31:0] cpu_addr, cpu_wdata, cpu_rdata;
    logic        cpu_stall;
    logic        host_req, host_we;
    logic [31:0] host_addr, host_wdata, host_rdata;
    logic        host_ack;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic        mem_read, mem_write;
    logic [1:0]  owner;

    int n_checks = 0;
    int n_fail   = 0;

    logic [31:0] mem [0:255];
    logic        preload;

    mem_port_arbiter #(
        .ADDR_W         (32),
        .DATA_W         (32),
        .MAX_WAIT       (8),
        .MAX_HOST_BURST (4)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .cpu_req    (cpu_req),
        .cpu_we     (cpu_we),
        .cpu_addr   (cpu_addr),
        .cpu_wdata  (cpu_wdata),
        .cpu_rdata  (cpu_rdata),
        .cpu_stall  (cpu_stall),
        .host_req   (host_req),
        .host_we    (host_we),
        .host_addr  (host_addr),
        .host_wdata (host_wdata),
        .host_ack   (host_ack),
        .host_rdata (host_rdata),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_read   (mem_read),
        .mem_write  (mem_write),
        .mem_rdata  (mem_rdata),
        .owner      (owner)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Word-addressed memory model: combinational read, write at the edge.
    always @(posedge clk) begin
        if (preload) begin
            for (int i = 0; i < 256; i++) mem[i] <= 32'h1000_0000 + i;
        end else if (mem_write) begin
            mem[mem_addr[9:2]] <= mem_wdata;
        end
    end

    assign mem_rdata = mem[mem_addr[9:2]];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        cpu_req = 0; cpu_we = 0; cpu_addr = 0; cpu_wdata = 0;
        host_req = 0; host_we = 0; host_addr = 0; host_wdata = 0;
    endtask

    task automatic test_reset();
        cpu_req = 1; host_req = 1; host_we = 1;
        host_addr = 32'h200; host_wdata = 32'hBAD0_BAD0;
        #2;
        n_checks++;
        if (owner !== 2'b00 || mem_write !== 1'b0 || mem_read !== 1'b0 ||
            host_ack !== 1'b0 || cpu_stall !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_outputs: owner=%b mw=%b mr=%b ack=%b stall=%b, required 00 0 0 0 0",
                     owner, mem_write, mem_read, host_ack, cpu_stall);
        end
        tick();
        preload = 0;
        n_checks++;
        if (mem[128] !== 32'h1000_0080) begin
            n_fail++;
            $display("FAIL reset_no_write: mem[0x200]=%h, required 10000080", mem[128]);
        end
        reset = 0;
        @(negedge clk);
        n_checks++;
        if (owner !== 2'b01 || host_ack !== 1'b0 || cpu_stall !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_release: owner=%b ack=%b stall=%b, required 01 0 0",
                     owner, host_ack, cpu_stall);
        end
        tick();
        idle_inputs();
        tick();
    endtask

    task automatic test_cpu_only();
        cpu_req = 1; cpu_we = 0; cpu_addr = 32'h0;
        @(negedge clk);
        n_checks++;
        if (owner !== 2'b01 || cpu_stall !== 1'b0 || mem_read !== 1'b1 ||
            cpu_rdata !== 32'h1000_0000) begin
            n_fail++;
            $display("FAIL cpu_read0: owner=%b stall=%b mr=%b rdata=%h, required 01 0 1 10000000",
                     owner, cpu_stall, mem_read, cpu_rdata);
        end
        tick();
        cpu_we = 1; cpu_addr = 32'h40; cpu_wdata = 32'hDEAD_BEEF;
        @(negedge clk);
        n_checks++;
        if (owner !== 2'b01 || cpu_stall !== 1'b0 || mem_write !== 1'b1 ||
            mem_addr !== 32'h40 || mem_wdata !== 32'hDEAD_BEEF) begin
            n_fail++;
            $display("FAIL cpu_write: owner=%b stall=%b mw=%b addr=%h wdata=%h, required 01 0 1 00000040 deadbeef",
                     owner, cpu_stall, mem_write, mem_addr, mem_wdata);
        end
        tick();
        cpu_we = 0;
        @(negedge clk);
        n_checks++;
        if (owner !== 2'b01 || cpu_stall !== 1'b0 || cpu_rdata !== 32'hDEAD_BEEF) begin
            n_fail++;
            $display("FAIL cpu_readback: owner=%b stall=%b rdata=%h, required 01 0 deadbeef",
                     owner, cpu_stall, cpu_rdata);
        end
        tick();
        idle_inputs();
        tick();
    endtask

    task automatic test_host_only();
        for (int i = 0; i < 3; i++) begin
            host_req = 1; host_we = 1;
            host_addr = 32'h100 + 4 * i; host_wdata = 32'hCAFE_0000 + i;
            @(negedge clk);
            n_checks++;
            if (host_ack !== 1'b1 || owner !== 2'b10 || mem_write !== 1'b1) begin
                n_fail++;
                $display("FAIL host_write_beat%0d: ack=%b owner=%b mw=%b, required 1 10 1",
                         i, host_ack, owner, mem_write);
            end
            tick();
        end
        for (int i = 0; i < 3; i++) begin
            host_we = 0; host_addr = 32'h100 + 4 * i;
            @(negedge clk);
            n_checks++;
            if (host_ack !== 1'b1 || host_rdata !== 32'hCAFE_0000 + i) begin
                n_fail++;
                $display("FAIL host_readback%0d: ack=%b rdata=%h, required 1 %h",
                         i, host_ack, host_rdata, 32'hCAFE_0000 + i);
            end
            tick();
        end
        idle_inputs();
        @(negedge clk);
        n_checks++;
        if (owner !== 2'b00 || mem_addr !== 32'h0 || mem_wdata !== 32'h0 ||
            mem_read !== 1'b0 || mem_write !== 1'b0 || host_ack !== 1'b0) begin
            n_fail++;
            $display("FAIL idle_bus: owner=%b addr=%h wdata=%h mr=%b mw=%b ack=%b, required all zero",
                     owner, mem_addr, mem_wdata, mem_read, mem_write, host_ack);
        end
        tick();
    endtask

    task automatic test_contention();
        logic [1:0] exp_owner;
        cpu_req = 1; cpu_addr = 32'h0;
        host_req = 1; host_addr = 32'h100;
        for (int i = 0; i < 24; i++) begin
            exp_owner = ((i % 12) < 8) ? 2'b01 : 2'b10;
            @(negedge clk);
            n_checks++;
            if (owner !== exp_owner || cpu_stall !== (exp_owner == 2'b10) ||
                host_ack !== (exp_owner == 2'b10)) begin
                n_fail++;
                $display("FAIL contention_cycle%0d: owner=%b stall=%b ack=%b, required owner %b",
                         i, owner, cpu_stall, host_ack, exp_owner);
            end
            tick();
        end
        idle_inputs();
        tick();
    endtask

    task automatic test_host_drop();
        logic [1:0] exp_owner;
        cpu_req = 1; cpu_addr = 32'h0;
        host_req = 1; host_addr = 32'h104;
        for (int i = 0; i < 10; i++) begin
            exp_owner = (i < 8) ? 2'b01 : 2'b10;
            @(negedge clk);
            n_checks++;
            if (owner !== exp_owner) begin
                n_fail++;
                $display("FAIL drop_lead%0d: owner=%b, required %b", i, owner, exp_owner);
            end
            tick();
        end
        host_req = 0;
        @(negedge clk);
        n_checks++;
        if (owner !== 2'b01 || cpu_stall !== 1'b0 || host_ack !== 1'b0) begin
            n_fail++;
            $display("FAIL drop_same_cycle: owner=%b stall=%b ack=%b, required 01 0 0",
                     owner, cpu_stall, host_ack);
        end
        tick();
        host_req = 1;
        for (int i = 0; i < 9; i++) begin
            exp_owner = (i < 8) ? 2'b01 : 2'b10;
            @(negedge clk);
            n_checks++;
            if (owner !== exp_owner) begin
                n_fail++;
                $display("FAIL drop_rewait%0d: owner=%b, required %b", i, owner, exp_owner);
            end
            tick();
        end
        idle_inputs();
        tick();
    endtask

    task automatic test_reset_mid_burst();
        cpu_req = 1; cpu_addr = 32'h0;
        host_req = 1; host_we = 0; host_addr = 32'h100;
        for (int i = 0; i < 10; i++) tick();
        host_we = 1; host_addr = 32'h200; host_wdata = 32'h1234_5678;
        reset = 1;
        @(negedge clk);
        n_checks++;
        if (mem_write !== 1'b0 || owner !== 2'b00 || host_ack !== 1'b0 || cpu_stall !== 1'b0) begin
            n_fail++;
            $display("FAIL midburst_reset: mw=%b owner=%b ack=%b stall=%b, required 0 00 0 0",
                     mem_write, owner, host_ack, cpu_stall);
        end
        tick();
        n_checks++;
        if (mem[128] !== 32'h1000_0080) begin
            n_fail++;
            $display("FAIL midburst_target: mem[0x200]=%h, required 10000080", mem[128]);
        end
        reset = 0;
        @(negedge clk);
        n_checks++;
        if (owner !== 2'b01 || cpu_stall !== 1'b0 || host_ack !== 1'b0) begin
            n_fail++;
            $display("FAIL midburst_release: owner=%b stall=%b ack=%b, required 01 0 0",
                     owner, cpu_stall, host_ack);
        end
        tick();
        idle_inputs();
        tick();
    endtask

    task automatic test_simultaneous();
        tick();
        cpu_req = 1; cpu_addr = 32'h40;
        host_req = 1; host_addr = 32'h108;
        @(negedge clk);
        n_checks++;
        if (owner !== 2'b01 || host_ack !== 1'b0 || cpu_stall !== 1'b0 ||
            cpu_rdata !== 32'hDEAD_BEEF) begin
            n_fail++;
            $display("FAIL simultaneous_first: owner=%b ack=%b stall=%b rdata=%h, required 01 0 0 deadbeef",
                     owner, host_ack, cpu_stall, cpu_rdata);
        end
        tick();
        idle_inputs();
        tick();
    endtask

    initial begin
        reset = 1;
        preload = 1;
        idle_inputs();
        test_reset();
        test_cpu_only();
        test_host_only();
        test_contention();
        test_host_drop();
        test_reset_mid_burst();
        test_simultaneous();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
